sprite_bounce_gen: RTL and testbench
====================================

SPRITE_BOUNCE_GEN -- requirements
Module: sprite_bounce_gen

Interface
REQ-001 Parameter N_SPRITES, default 3: number of sprites; legal range 1..4.
REQ-002 Parameter COORD_W, default 10: width of all pixel coordinates.
REQ-003 Parameter H_ACTIVE, default 640; V_ACTIVE, default 480: visible area in pixels and lines.
REQ-004 Parameter SPR_W, default 64; SPR_H, default 48: sprite width and height in pixels.
REQ-005 Parameter STEP, default 2: pixels moved per axis per frame; 1 <= STEP < SPR_W.
REQ-006 Parameter BG_RGB, default 12'h137: 4-bit R,G,B background colour for active pixels not covered by a sprite.
REQ-007 pix_clk  input  1  pixel clock; the only clock.
REQ-008 reset  input  1  reset; asynchronous and active-low.
REQ-009 hcount  input  COORD_W  current pixel column from the timing generator.
REQ-010 vcount  input  COORD_W  current line from the timing generator.
REQ-011 de  input  1  data enable from the timing generator; high in the visible area.
REQ-012 pause  input  1  high freezes all sprite motion.
REQ-013 sdl_de  output  1  registered de.
REQ-014 sdl_x, sdl_y  output  COORD_W each  registered hcount and vcount.
REQ-015 sdl_r, sdl_g, sdl_b  output  8 each  registered colour.
REQ-016 overlap  output  1  registered flag: two or more sprites cover the current pixel.

Function
REQ-017 All outputs SHALL have 1-cycle latency: the values at clock edge n reflect the hcount, vcount and de sampled at edge n.
REQ-018 Each sprite i SHALL hold the registers x_i, y_i (COORD_W bits) and the direction bits dx_i, dy_i, where 1 means increasing.
REQ-019 Sprite i SHALL cover a pixel when x_i <= hcount < x_i+SPR_W and y_i <= vcount < y_i+SPR_H; comparisons SHALL use COORD_W+1 bits so that they do not overflow.
REQ-020 Sprite colour nibbles SHALL be: i=0 F,0,0; i=1 0,F,0; i=2 0,0,F; i=3 F,F,0.
REQ-021 Colour priority SHALL be: when de is low, black (all zero); otherwise the covering sprite with the lowest index; otherwise BG_RGB.
REQ-022 Each 8-bit output channel SHALL be the selected nibble repeated twice (F -> 8'hFF).
REQ-023 overlap SHALL be high only when de is high and at least two sprites cover the pixel.
REQ-024 frame_tick SHALL be an internal single-cycle pulse, high when hcount==0 and vcount==V_ACTIVE.
REQ-025 On frame_tick with pause low, every sprite SHALL update once, with the X and Y axes updated independently.
REQ-026 On frame_tick with pause high, no position or direction register SHALL change.
REQ-027 Positive-direction step: if x+STEP+SPR_W > H_ACTIVE, then x <= H_ACTIVE-SPR_W and dx <= 0; otherwise x <= x+STEP.
REQ-028 Negative-direction step: if x < STEP, then x <= 0 and dx <= 1; otherwise x <= x-STEP.
REQ-029 The Y axis SHALL follow the same rules as REQ-027 and REQ-028, using V_ACTIVE and SPR_H.
REQ-030 A sprite SHALL never be placed outside 0..H_ACTIVE-SPR_W in X or 0..V_ACTIVE-SPR_H in Y.
REQ-031 Positions SHALL change only in blanking, so that no visible frame tears.
REQ-032 When hcount and vcount hold at frame_tick values for several cycles, only the first cycle SHALL update positions; frame_tick SHALL be edge-qualified against the previous cycle.

Reset
REQ-033 While reset is low, all outputs SHALL be 0.
REQ-034 While reset is low, sprite i SHALL be set to x_i=32+96*i, y_i=32+64*i, dx_i=1, and dy_i=1 for even i, 0 for odd i.
REQ-035 Reset asserted mid-frame SHALL clear all outputs immediately, without waiting for a clock edge.
REQ-036 The first frame_tick after reset release SHALL move sprites from their REQ-034 positions.

Verification
REQ-037 Reset check: reset low, then released; hcount=40, vcount=40, de=1 -> next cycle sdl_r=8'hFF, sdl_g=0, sdl_b=0, sdl_x=40, overlap=0.
REQ-038 Background and blanking: pixel (600,470) with de=1 -> sdl_r/g/b = 8'h11/8'h33/8'h77; same pixel with de=0 -> all 0.
REQ-039 Motion: one frame_tick with pause=0 -> x_0=34, y_0=34, x_1=130, y_1=94; drive pixel (34,34) -> red output.
REQ-040 Wall bounce: force x_0=575 with dx_0=1, then one tick -> x_0=576, dx_0=0; next tick -> x_0=574.
REQ-041 Pause and overlap: pause=1 for 3 ticks -> positions unchanged; drive sprites 0 and 1 to overlap -> red colour and overlap=1 in the overlapped region only.

Source files
------------

// File: rtl/sprite_bounce_gen.sv
// Bouncing-sprite test pattern: N_SPRITES solid rectangles move once per frame
// in vertical blanking and are composited over a flat background, one cycle late.
module sprite_bounce_gen #(
  parameter int          N_SPRITES = 3,
  parameter int          COORD_W   = 10,
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter int          SPR_W     = 64,
  parameter int          SPR_H     = 48,
  parameter int          STEP      = 2,
  parameter logic [11:0] BG_RGB    = 12'h137
) (
  input  logic               pix_clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  input  logic               de,
  input  logic               pause,
  output logic               sdl_de,
  output logic [COORD_W-1:0] sdl_x,
  output logic [COORD_W-1:0] sdl_y,
  output logic [7:0]         sdl_r,
  output logic [7:0]         sdl_g,
  output logic [7:0]         sdl_b,
  output logic               overlap
);

  localparam logic [COORD_W+1:0] X_LIM  = (COORD_W+2)'(H_ACTIVE - SPR_W);
  localparam logic [COORD_W+1:0] Y_LIM  = (COORD_W+2)'(V_ACTIVE - SPR_H);
  localparam logic [COORD_W+1:0] STEP_E = (COORD_W+2)'(STEP);
  localparam logic [COORD_W:0]   SPR_WE = (COORD_W+1)'(SPR_W);
  localparam logic [COORD_W:0]   SPR_HE = (COORD_W+1)'(SPR_H);

  logic [COORD_W-1:0]   x_q [N_SPRITES];
  logic [COORD_W-1:0]   y_q [N_SPRITES];
  logic [N_SPRITES-1:0] dx_q;
  logic [N_SPRITES-1:0] dy_q;
  logic                 tick_prev_q;

  logic                 tick_match_p0;
  logic                 frame_tick_p0;
  logic [N_SPRITES-1:0] cover_p0;
  logic [11:0]          rgb_p0;
  logic                 ovl_p0;
  logic                 seen_p0;

  // One axis step with wall clamp; returns {new_dir, new_pos}.
  function automatic logic [COORD_W:0] step_axis(input logic [COORD_W-1:0] pos,
                                                 input logic               dir,
                                                 input logic [COORD_W+1:0] lim);
    logic [COORD_W+1:0] pos_e;
    logic [COORD_W+1:0] nxt;
    pos_e = {2'b00, pos};
    nxt   = '0;
    if (dir) begin
      nxt = pos_e + STEP_E;
      if (nxt > lim) step_axis = {1'b0, lim[COORD_W-1:0]};
      else           step_axis = {1'b1, nxt[COORD_W-1:0]};
    end else begin
      if (pos_e < STEP_E) step_axis = {1'b1, {COORD_W{1'b0}}};
      else begin
        nxt       = pos_e - STEP_E;
        step_axis = {1'b0, nxt[COORD_W-1:0]};
      end
    end
  endfunction

  function automatic logic [11:0] spr_rgb(input int idx);
    case (idx)
      0:       spr_rgb = 12'hF00;
      1:       spr_rgb = 12'h0F0;
      2:       spr_rgb = 12'h00F;
      default: spr_rgb = 12'hFF0;
    endcase
  endfunction

  // Stage p0: tick detection and compositing from current inputs
  assign tick_match_p0 = (hcount == '0) && (vcount == COORD_W'(V_ACTIVE));
  assign frame_tick_p0 = tick_match_p0 && !tick_prev_q;

  always_comb begin
    cover_p0 = '0;
    rgb_p0   = BG_RGB;
    ovl_p0   = 1'b0;
    seen_p0  = 1'b0;
    for (int i = 0; i < N_SPRITES; i++) begin
      cover_p0[i] = ({1'b0, hcount} >= {1'b0, x_q[i]}) &&
                    ({1'b0, hcount} <  {1'b0, x_q[i]} + SPR_WE) &&
                    ({1'b0, vcount} >= {1'b0, y_q[i]}) &&
                    ({1'b0, vcount} <  {1'b0, y_q[i]} + SPR_HE);
    end
    // Walk from the highest index down so the lowest covering index wins.
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (cover_p0[i]) rgb_p0 = spr_rgb(i);
    end
    for (int i = 0; i < N_SPRITES; i++) begin
      if (cover_p0[i]) begin
        if (seen_p0) ovl_p0 = 1'b1;
        seen_p0 = 1'b1;
      end
    end
    if (!de) begin
      rgb_p0 = '0;
      ovl_p0 = 1'b0;
    end
  end

  always_ff @(posedge pix_clk or negedge reset) begin
    if (!reset) begin
      tick_prev_q <= 1'b0;
      for (int i = 0; i < N_SPRITES; i++) begin
        x_q[i]  <= COORD_W'(32 + 96 * i);
        y_q[i]  <= COORD_W'(32 + 64 * i);
        dx_q[i] <= 1'b1;
        dy_q[i] <= ((i % 2) == 0);
      end
    end else begin
      tick_prev_q <= tick_match_p0;
      if (frame_tick_p0 && !pause) begin
        for (int i = 0; i < N_SPRITES; i++) begin
          {dx_q[i], x_q[i]} <= step_axis(x_q[i], dx_q[i], X_LIM);
          {dy_q[i], y_q[i]} <= step_axis(y_q[i], dy_q[i], Y_LIM);
        end
      end
    end
  end

  // Stage p1: registered video outputs
  always_ff @(posedge pix_clk or negedge reset) begin
    if (!reset) begin
      sdl_de  <= 1'b0;
      sdl_x   <= '0;
      sdl_y   <= '0;
      sdl_r   <= '0;
      sdl_g   <= '0;
      sdl_b   <= '0;
      overlap <= 1'b0;
    end else begin
      sdl_de  <= de;
      sdl_x   <= hcount;
      sdl_y   <= vcount;
      sdl_r   <= {2{rgb_p0[11:8]}};
      sdl_g   <= {2{rgb_p0[7:4]}};
      sdl_b   <= {2{rgb_p0[3:0]}};
      overlap <= ovl_p0;
    end
  end

endmodule

// File: tb/tb_sprite_bounce_gen.sv
// Directed bench for sprite_bounce_gen: reset, compositing, motion, pause,
// overlap and wall bounce with hand-computed positions.
module tb_sprite_bounce_gen;

  logic       pix_clk = 1'b0;
  logic       reset;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       de;
  logic       pause;
  logic       sdl_de;
  logic [9:0] sdl_x;
  logic [9:0] sdl_y;
  logic [7:0] sdl_r;
  logic [7:0] sdl_g;
  logic [7:0] sdl_b;
  logic       overlap;

  int n_tests = 0;
  int n_fail  = 0;

  sprite_bounce_gen dut (
    .pix_clk (pix_clk),
    .reset   (reset),
    .hcount  (hcount),
    .vcount  (vcount),
    .de      (de),
    .pause   (pause),
    .sdl_de  (sdl_de),
    .sdl_x   (sdl_x),
    .sdl_y   (sdl_y),
    .sdl_r   (sdl_r),
    .sdl_g   (sdl_g),
    .sdl_b   (sdl_b),
    .overlap (overlap)
  );

  always #5 pix_clk = ~pix_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic d);
    hcount = h; vcount = v; de = d;
    @(posedge pix_clk); #1;
  endtask

  task automatic tick();
    pix(10'd0, 10'd480, 1'b0);
    pix(10'd1, 10'd480, 1'b0);
  endtask

  task automatic chk_rgb(input string name, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b);
    n_tests++;
    if ({sdl_r, sdl_g, sdl_b} !== {r, g, b}) begin
      n_fail++;
      $display("FAIL %s: rgb got %h/%h/%h exp %h/%h/%h", name, sdl_r, sdl_g, sdl_b, r, g, b);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; pause = 1'b0;
    hcount = 10'd40; vcount = 10'd40; de = 1'b1;
    repeat (3) @(posedge pix_clk);
    #1;
    n_tests++;
    if ({sdl_de, sdl_x, sdl_y, sdl_r, sdl_g, sdl_b, overlap} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got de=%b x=%0d r=%h ovl=%b exp all 0", sdl_de, sdl_x, sdl_r, overlap);
    end
    n_tests++;
    if ({dut.x_q[0], dut.y_q[0], dut.x_q[1], dut.y_q[1], dut.x_q[2], dut.y_q[2]} !==
        {10'd32, 10'd32, 10'd128, 10'd96, 10'd224, 10'd160}) begin
      n_fail++;
      $display("FAIL reset_pos: got x0=%0d y0=%0d x1=%0d y1=%0d x2=%0d y2=%0d exp 32 32 128 96 224 160",
               dut.x_q[0], dut.y_q[0], dut.x_q[1], dut.y_q[1], dut.x_q[2], dut.y_q[2]);
    end
    n_tests++;
    if ({dut.dx_q, dut.dy_q} !== {3'b111, 3'b101}) begin
      n_fail++;
      $display("FAIL reset_dir: got dx=%b dy=%b exp 111 101", dut.dx_q, dut.dy_q);
    end
    reset = 1'b1;
    pix(10'd40, 10'd40, 1'b1);
    chk_rgb("first_pixel", 8'hFF, 8'h00, 8'h00);
    n_tests++;
    if ({sdl_de, sdl_x, sdl_y, overlap} !== {1'b1, 10'd40, 10'd40, 1'b0}) begin
      n_fail++;
      $display("FAIL first_pixel_ctl: got de=%b x=%0d y=%0d ovl=%b exp 1 40 40 0", sdl_de, sdl_x, sdl_y, overlap);
    end
  endtask

  task automatic test_background();
    pix(10'd600, 10'd470, 1'b1);
    chk_rgb("background", 8'h11, 8'h33, 8'h77);
    pix(10'd600, 10'd470, 1'b0);
    chk_rgb("blanking", 8'h00, 8'h00, 8'h00);
    n_tests++;
    if (sdl_de !== 1'b0) begin
      n_fail++;
      $display("FAIL blanking_de: got %b exp 0", sdl_de);
    end
  endtask

  task automatic test_motion();
    tick();
    n_tests++;
    if ({dut.x_q[0], dut.y_q[0], dut.x_q[1], dut.y_q[1]} !== {10'd34, 10'd34, 10'd130, 10'd94}) begin
      n_fail++;
      $display("FAIL motion: got x0=%0d y0=%0d x1=%0d y1=%0d exp 34 34 130 94",
               dut.x_q[0], dut.y_q[0], dut.x_q[1], dut.y_q[1]);
    end
    pix(10'd34, 10'd34, 1'b1);
    chk_rgb("moved_corner", 8'hFF, 8'h00, 8'h00);
    pix(10'd33, 10'd34, 1'b1);
    chk_rgb("left_of_moved", 8'h11, 8'h33, 8'h77);
  endtask

  task automatic test_hold();
    hcount = 10'd0; vcount = 10'd480; de = 1'b0;
    repeat (3) @(posedge pix_clk);
    #1;
    pix(10'd1, 10'd480, 1'b0);
    n_tests++;
    if ({dut.x_q[0], dut.y_q[1]} !== {10'd36, 10'd92}) begin
      n_fail++;
      $display("FAIL hold_single_step: got x0=%0d y1=%0d exp 36 92", dut.x_q[0], dut.y_q[1]);
    end
  endtask

  task automatic test_pause();
    pause = 1'b1;
    repeat (3) tick();
    pause = 1'b0;
    n_tests++;
    if ({dut.x_q[0], dut.y_q[0], dut.x_q[1], dut.y_q[1], dut.dx_q, dut.dy_q} !==
        {10'd36, 10'd36, 10'd132, 10'd92, 3'b111, 3'b101}) begin
      n_fail++;
      $display("FAIL pause: got x0=%0d y0=%0d x1=%0d y1=%0d dx=%b dy=%b exp 36 36 132 92 111 101",
               dut.x_q[0], dut.y_q[0], dut.x_q[1], dut.y_q[1], dut.dx_q, dut.dy_q);
    end
  endtask

  // After 233 moves: sprite 0 at (498,368), sprite 1 at (560,368), both bounced.
  task automatic test_overlap();
    repeat (231) tick();
    n_tests++;
    if ({dut.x_q[0], dut.y_q[0], dut.x_q[1], dut.y_q[1]} !== {10'd498, 10'd368, 10'd560, 10'd368}) begin
      n_fail++;
      $display("FAIL overlap_pos: got x0=%0d y0=%0d x1=%0d y1=%0d exp 498 368 560 368",
               dut.x_q[0], dut.y_q[0], dut.x_q[1], dut.y_q[1]);
    end
    pix(10'd560, 10'd370, 1'b1);
    chk_rgb("overlap_colour", 8'hFF, 8'h00, 8'h00);
    n_tests++;
    if (overlap !== 1'b1) begin n_fail++; $display("FAIL overlap_in: got %b exp 1", overlap); end
    pix(10'd562, 10'd370, 1'b1);
    chk_rgb("sprite1_only", 8'h00, 8'hFF, 8'h00);
    n_tests++;
    if (overlap !== 1'b0) begin n_fail++; $display("FAIL overlap_s1: got %b exp 0", overlap); end
    pix(10'd559, 10'd370, 1'b1);
    n_tests++;
    if (overlap !== 1'b0) begin n_fail++; $display("FAIL overlap_s0: got %b exp 0", overlap); end
    pix(10'd560, 10'd370, 1'b0);
    n_tests++;
    if ({overlap, sdl_r} !== 9'd0) begin
      n_fail++;
      $display("FAIL overlap_blank: got ovl=%b r=%h exp 0 00", overlap, sdl_r);
    end
  endtask

  task automatic test_wall();
    logic [9:0] exp_x [4] = '{10'd574, 10'd576, 10'd576, 10'd574};
    logic       exp_d [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    repeat (38) tick();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      n_tests++;
      if ({dut.x_q[0], dut.dx_q[0]} !== {exp_x[k], exp_d[k]}) begin
        n_fail++;
        $display("FAIL wall_%0d: got x0=%0d dx0=%b exp %0d %b", k, dut.x_q[0], dut.dx_q[0], exp_x[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    pix(10'd600, 10'd470, 1'b1);
    chk_rgb("pre_reset", 8'h11, 8'h33, 8'h77);
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({sdl_de, sdl_x, sdl_y, sdl_r, sdl_g, sdl_b, overlap} !== '0 || dut.x_q[0] !== 10'd32) begin
      n_fail++;
      $display("FAIL async_reset: got de=%b x=%0d r=%h x0=%0d exp 0 0 00 32", sdl_de, sdl_x, sdl_r, dut.x_q[0]);
    end
    @(posedge pix_clk); #1;
    reset = 1'b1;
    tick();
    n_tests++;
    if ({dut.x_q[0], dut.y_q[0], dut.dx_q[0]} !== {10'd34, 10'd34, 1'b1}) begin
      n_fail++;
      $display("FAIL first_tick_after_reset: got x0=%0d y0=%0d dx0=%b exp 34 34 1",
               dut.x_q[0], dut.y_q[0], dut.dx_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_background();
    test_motion();
    test_hold();
    test_pause();
    test_overlap();
    test_wall();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
